// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file constants and the writeback request record.
package rf_writeback_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; search starts at ptr and wraps, ptr moves past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, ptr_nxt;
  logic          found;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_nxt  = PW'((i + 1) % N);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_nxt  = PW'((i + 1) % N);
      end
    end
    if (reset) grant = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nxt;
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates writeback sources onto the single RF write port through one stage
// register, and flags read ports that must bypass the not-yet-committed write.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_data_in,
  input  logic [ADDR_W-1:0]         rs,
  input  logic [ADDR_W-1:0]         rt,
  output logic                      byp0_hit,
  output logic                      byp1_hit,
  output logic [DATA_W-1:0]         byp_data
);
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;
  logic               stage_valid;
  logic [ADDR_W-1:0]  stage_rd;
  logic [DATA_W-1:0]  stage_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  // Grant is one-hot, so an OR-reduction acts as the data mux.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | req_rd[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_rd    <= '0;
      stage_data  <= '0;
    end else begin
      stage_valid <= |grant;
      if (|grant) begin
        stage_rd   <= sel_rd;
        stage_data <= sel_data;
      end
    end
  end

  // Writes to the zero register are consumed but never reach the RF.
  assign rf_write   = stage_valid && (stage_rd != ADDR_W'(ZERO_REG));
  assign rf_rd      = stage_rd;
  assign rf_data_in = stage_data;
  assign byp0_hit   = rf_write && (stage_rd == rs);
  assign byp1_hit   = rf_write && (stage_rd == rt);
  assign byp_data   = stage_data;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomised and directed checks of rf_writeback_arbiter against a behavioural model.
module tb_rf_writeback_arbiter;
  import rf_writeback_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = REG_ADDR_W;
  localparam int DW = REG_DATA_W;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic            rf_write, byp0_hit, byp1_hit;
  logic [AW-1:0]   rf_rd, rs, rt;
  logic [DW-1:0]   rf_data_in, byp_data;

  int      vectors = 0;
  int      errors  = 0;
  int      mp      = 0;
  wb_req_t ms      = '0;
  logic [DW-1:0] mrf [NUM_REGS];
  logic [DW-1:0] drf [NUM_REGS];

  rf_writeback_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_write(rf_write), .rf_rd(rf_rd), .rf_data_in(rf_data_in),
    .rs(rs), .rt(rt), .byp0_hit(byp0_hit), .byp1_hit(byp1_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  // Advance one clock; the model RF and a copy fed by the DUT's write port both
  // commit at the edge, except while reset holds the pipeline.
  task automatic tick(output int g);
    logic w, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = reset ? -1 : pick(req_valid, mp);
    w = rf_write; a = rf_rd; d = rf_data_in; r = reset;
    @(posedge clk);
    if (!r && w === 1'b1) drf[a] = d;
    if (!r && ms.valid && ms.rd != ZERO_REG) mrf[ms.rd] = ms.data;
    if (r) begin
      mp = 0; ms = '0;
    end else if (g >= 0) begin
      mp = (g + 1) % N;
      ms.valid = 1'b1;
      ms.rd    = req_rd[g*AW +: AW];
      ms.data  = req_data[g*DW +: DW];
    end else begin
      ms.valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    int g;
    reset = 1'b1; req_valid = '0; rs = '0; rt = '0;
    tick(g);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b1; req_valid = '1; rs = '0; rt = '0;
    req_rd = N*AW'($urandom); req_data = {$urandom, $urandom, $urandom};
    repeat (2) begin
      #1;
      vectors++;
      if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
      tick(g);
      vectors++;
      if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write: got %b want 0", rf_write); end
    end
    reset = 1'b0; #1;
    vectors++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_release_ready: got %b want 001", req_ready); end
    tick(g);
    req_valid = '0;
  endtask

  task automatic test_rotation();
    int g;
    logic [DW-1:0] d [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom;
      req_rd[i*AW +: AW]   = AW'(i + 1);
      req_data[i*DW +: DW] = d[i];
    end
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (req_ready !== onehot(c % N)) begin
        errors++; $display("FAIL rotation_ready[%0d]: got %b want %b", c, req_ready, onehot(c % N));
      end
      tick(g);
      vectors++;
      if (rf_write !== 1'b1 || rf_rd !== AW'(c % N + 1) || rf_data_in !== d[c % N]) begin
        errors++;
        $display("FAIL rotation_write[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                 c, rf_write, rf_rd, rf_data_in, c % N + 1, d[c % N]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_pointer_skip();
    int g;
    do_reset();
    req_rd = '0; req_data = '0;
    req_rd[0*AW +: AW] = AW'(9);  req_data[0*DW +: DW] = 32'h0000_0a0a;
    req_rd[2*AW +: AW] = AW'(11); req_data[2*DW +: DW] = 32'h0000_0c0c;
    req_valid = 3'b001; #1;
    tick(g);
    #1;
    vectors++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL skip_only_req0: got %b want 001", req_ready); end
    tick(g);
    req_valid = 3'b101; #1;
    vectors++;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL skip_grant2: got %b want 100", req_ready); end
    tick(g);
    vectors++;
    if (rf_rd !== AW'(11) || rf_data_in !== 32'h0000_0c0c) begin
      errors++; $display("FAIL skip_write: got rd=%0d data=%h want rd=11 data=00000c0c", rf_rd, rf_data_in);
    end
    req_valid = '0;
  endtask

  task automatic test_zero_reg();
    int g;
    do_reset();
    req_rd = '0; req_data = '0;
    req_data[0*DW +: DW] = 32'hDEADBEEF;
    req_valid = 3'b001; rs = '0; rt = '0; #1;
    vectors++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL zero_ready: got %b want 001", req_ready); end
    tick(g);
    req_valid = '0; #1;
    vectors++;
    if (rf_write !== 1'b0 || byp0_hit !== 1'b0 || byp1_hit !== 1'b0) begin
      errors++; $display("FAIL zero_no_write: got we=%b h0=%b h1=%b want 0 0 0", rf_write, byp0_hit, byp1_hit);
    end
    vectors++;
    if (rf_data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_consumed: got %h want deadbeef", rf_data_in); end
    #1;
    vectors++;
    if (req_ready !== '0) begin errors++; $display("FAIL zero_idle: got %b want 000", req_ready); end
  endtask

  task automatic test_bypass();
    int g;
    do_reset();
    req_rd = '0; req_data = '0;
    req_rd[1*AW +: AW] = AW'(7); req_data[1*DW +: DW] = 32'h1234;
    req_valid = 3'b010; #1;
    vectors++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL bypass_ready: got %b want 010", req_ready); end
    tick(g);
    req_valid = '0; rs = AW'(7); rt = AW'(8); #1;
    vectors++;
    if (rf_write !== 1'b1 || byp0_hit !== 1'b1 || byp1_hit !== 1'b0 || byp_data !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_hit: got we=%b h0=%b h1=%b data=%h want 1 1 0 00001234",
               rf_write, byp0_hit, byp1_hit, byp_data);
    end
    tick(g);
    vectors++;
    if (drf[7] !== 32'h1234) begin errors++; $display("FAIL bypass_commit: got %h want 00001234", drf[7]); end
    rs = '0; rt = '0;
  endtask

  task automatic test_reset_midflight();
    int g;
    logic [DW-1:0] old;
    do_reset();
    old = drf[5];
    req_rd = '0; req_data = '0;
    req_rd[0*AW +: AW] = AW'(5); req_data[0*DW +: DW] = ~old;
    req_valid = 3'b001; #1;
    tick(g);
    req_valid = 3'b110; reset = 1'b1; #1;
    vectors++;
    if (req_ready !== '0) begin errors++; $display("FAIL midreset_ready: got %b want 000", req_ready); end
    tick(g);
    vectors++;
    if (rf_write !== 1'b0) begin errors++; $display("FAIL midreset_rf_write: got %b want 0", rf_write); end
    vectors++;
    if (drf[5] !== old) begin errors++; $display("FAIL midreset_reg5: got %h want %h", drf[5], old); end
    reset = 1'b0; #1;
    vectors++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL midreset_restart: got %b want 010", req_ready); end
    tick(g);
    req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    int waits [N];
    logic exp_we;
    do_reset();
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (((req_valid >> i) & 1) == 0 && $urandom_range(2, 0) == 0) begin
          req_valid = req_valid | onehot(i);
          req_rd[i*AW +: AW]   = AW'($urandom);
          req_data[i*DW +: DW] = $urandom;
        end
        if (((req_valid >> i) & 1) != 0) waits[i]++;
      end
      #1;
      vectors++;
      if (req_ready !== onehot(pick(req_valid, mp))) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, onehot(pick(req_valid, mp)));
      end
      tick(g);
      if (g >= 0) begin
        vectors++;
        if (waits[g] > N) begin errors++; $display("FAIL rand_fairness: req %0d waited %0d want <=%0d", g, waits[g], N); end
        waits[g] = 0;
        req_valid = req_valid & ~onehot(g);
      end
      rs = ($urandom_range(1, 0) == 1) ? ms.rd : AW'($urandom);
      rt = ($urandom_range(1, 0) == 1) ? ms.rd : AW'($urandom);
      #1;
      exp_we = ms.valid && (ms.rd != ZERO_REG);
      vectors++;
      if (rf_write !== exp_we || rf_rd !== ms.rd || rf_data_in !== ms.data || byp_data !== ms.data ||
          byp0_hit !== (exp_we && ms.rd == rs) || byp1_hit !== (exp_we && ms.rd == rt)) begin
        errors++;
        $display("FAIL rand_stage[%0d]: got we=%b rd=%0d d=%h h0=%b h1=%b want we=%b rd=%0d d=%h rs=%0d rt=%0d",
                 c, rf_write, rf_rd, rf_data_in, byp0_hit, byp1_hit, exp_we, ms.rd, ms.data, rs, rt);
      end
    end
    req_valid = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      vectors++;
      if (drf[r] !== mrf[r]) begin errors++; $display("FAIL rand_regfile[%0d]: got %h want %h", r, drf[r], mrf[r]); end
    end
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin mrf[r] = '0; drf[r] = '0; end
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0; rs = '0; rt = '0;
    test_reset();
    test_rotation();
    test_pointer_skip();
    test_zero_reg();
    test_bypass();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
